// File: rtl/zero_alloc_pkg.sv
// Shared types, defaults and helpers for the array-handle allocator.
// Latency: none, because the package holds only declarations.
// Backpressure: none, because the package holds only declarations.
// Contents: default id width, id/length typedefs, counter-width helper, status enum.
package zero_alloc_pkg;

  localparam int DefaultMemoryElementWidth = 12;

  typedef logic [DefaultMemoryElementWidth-1:0] id_t;
  typedef logic [DefaultMemoryElementWidth-1:0] len_t;

  // Outcome of a request. Used inside the allocator and by benches.
  typedef enum logic [1:0] {
    OK          = 2'd0,
    EXHAUSTED   = 2'd1,
    DOUBLE_FREE = 2'd2,
    RANGE       = 2'd3
  } alloc_status_e;

  // Width needed to count 0..n_arrays inclusive.
  function automatic int count_width(input int n_arrays);
    return $clog2(n_arrays + 1);
  endfunction

endpackage

// File: rtl/array_allocator_if.sv
// Request/response bundle between an array-handle client and the allocator.
// Latency: none of its own; the signals are plain wires.
// Backpressure: none; each request is answered by an ack or err pulse one cycle later.
// Ports: master = client (drives requests, len reports, rd_array); slave = allocator.
interface array_allocator_if
  import zero_alloc_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultMemoryElementWidth,
  parameter int CountWidth         = count_width(8)
);

  logic                          alloc_req;
  logic                          free_req;
  logic [MemoryElementWidth-1:0] free_id;
  logic                          alloc_ack;
  logic [MemoryElementWidth-1:0] alloc_id;
  logic                          alloc_err;
  logic                          free_ack;
  logic                          free_err;
  logic                          len_we;
  logic [MemoryElementWidth-1:0] len_array;
  logic [MemoryElementWidth-1:0] len_index;
  logic [MemoryElementWidth-1:0] rd_array;
  logic [MemoryElementWidth-1:0] rd_len;
  logic [CountWidth-1:0]         in_use;
  logic [CountWidth-1:0]         high_water;

  modport master (
    output alloc_req, free_req, free_id, len_we, len_array, len_index, rd_array,
    input  alloc_ack, alloc_id, alloc_err, free_ack, free_err, rd_len, in_use, high_water
  );

  modport slave (
    input  alloc_req, free_req, free_id, len_we, len_array, len_index, rd_array,
    output alloc_ack, alloc_id, alloc_err, free_ack, free_err, rd_len, in_use, high_water
  );

endinterface

// File: rtl/array_free_stack.sv
// LIFO of released array ids. Push and pop in the same cycle replace the top entry.
// Latency: top and empty are combinational from the stored state; push and pop take effect at the next edge.
// Backpressure: a pop when empty and a push when full are ignored.
// Ports: clock, reset_n, push/push_id, pop, top, empty, count.
module array_free_stack #(
  parameter int Width      = 12,
  parameter int Depth      = 8,
  parameter int CountWidth = $clog2(Depth + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [Width-1:0]      push_id,
  input  logic                  pop,
  output logic [Width-1:0]      top,
  output logic                  empty,
  output logic [CountWidth-1:0] count
);

  localparam int                    PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CountWidth-1:0] DepthCnt = CountWidth'(Depth);

  logic [Width-1:0]      mem [Depth];
  logic [CountWidth-1:0] count_q;
  logic [PtrW-1:0]       top_ptr;
  logic [PtrW-1:0]       wr_ptr;
  logic                  do_pop;
  logic                  do_push;

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign top_ptr = PtrW'(count_q - CountWidth'(1));
  assign top     = empty ? '0 : mem[top_ptr];

  assign do_pop  = pop && !empty;
  // A simultaneous pop frees a slot, so a push is allowed even when full.
  assign do_push = push && (do_pop || (count_q != DepthCnt));
  // With push+pop the new id overwrites the popped top slot.
  assign wr_ptr  = do_pop ? top_ptr : PtrW'(count_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (do_push && !do_pop) begin
      count_q <= count_q + CountWidth'(1);
    end else if (do_pop && !do_push) begin
      count_q <= count_q - CountWidth'(1);
    end
  end

  // Storage needs no reset: entries at or above count_q are never read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

endmodule

// File: rtl/array_allocator.sv
// Shared allocator for array handles: ids come from a freed-id LIFO or a fresh counter; it also tracks array lengths.
// Latency: 1 cycle from request to ack/err pulse; rd_len is combinational.
// Backpressure: none; requests are legal every cycle, and refusal is signalled by alloc_err or free_err.
// Ports: clock, reset_n (async active-low), bus (array_allocator_if.slave).
module array_allocator
  import zero_alloc_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultMemoryElementWidth,
  parameter int NArrays            = 8,
  parameter int CountWidth         = count_width(NArrays)
) (
  input  logic             clock,
  input  logic             reset_n,
  array_allocator_if.slave bus
);

  localparam int                    W          = MemoryElementWidth;
  localparam int                    IdxW       = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam logic [W:0]            NArraysId  = (W + 1)'(NArrays);
  localparam logic [CountWidth-1:0] NArraysCnt = CountWidth'(NArrays);

  // State
  logic [NArrays-1:0]    live;
  logic [W-1:0]          lens [NArrays];
  logic [CountWidth-1:0] high_water_q;
  logic [CountWidth-1:0] in_use_q;
  logic [W-1:0]          alloc_id_q;
  logic                  alloc_ack_q;
  logic                  alloc_err_q;
  logic                  free_ack_q;
  logic                  free_err_q;

  // Free stack
  logic                  stack_push;
  logic                  stack_pop;
  logic                  stack_empty;
  logic [W-1:0]          stack_top;
  logic [CountWidth-1:0] unused_stack_count;

  array_free_stack #(
    .Width      (W),
    .Depth      (NArrays),
    .CountWidth (CountWidth)
  ) u_free_stack (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (stack_push),
    .push_id (bus.free_id),
    .pop     (stack_pop),
    .top     (stack_top),
    .empty   (stack_empty),
    .count   (unused_stack_count)
  );

  // Range checks compare full ids, so high bits cannot alias onto a valid slot.
  logic            free_in_range;
  logic            len_in_range;
  logic            rd_in_range;
  logic [IdxW-1:0] free_idx;
  logic [IdxW-1:0] len_idx;
  logic [IdxW-1:0] rd_idx;
  logic [IdxW-1:0] alloc_idx;

  assign free_in_range = ({1'b0, bus.free_id}   < NArraysId);
  assign len_in_range  = ({1'b0, bus.len_array} < NArraysId);
  assign rd_in_range   = ({1'b0, bus.rd_array}  < NArraysId);
  assign free_idx      = bus.free_id[IdxW-1:0];
  assign len_idx       = bus.len_array[IdxW-1:0];
  assign rd_idx        = bus.rd_array[IdxW-1:0];

  // Free decision, evaluated before the allocation.
  alloc_status_e free_status;
  logic          free_ok;

  always_comb begin
    free_status = OK;
    if (!free_in_range) begin
      free_status = RANGE;
    end else if (!live[free_idx]) begin
      free_status = DOUBLE_FREE;
    end
  end

  assign free_ok = bus.free_req && (free_status == OK);

  // Allocation source priority: same-cycle freed id, then stack, then fresh counter.
  alloc_status_e alloc_status;
  logic [W-1:0]  alloc_id_nxt;
  logic          hw_inc;
  logic          alloc_ok;

  always_comb begin
    alloc_status = OK;
    alloc_id_nxt = alloc_id_q;
    stack_pop    = 1'b0;
    hw_inc       = 1'b0;
    if (bus.alloc_req) begin
      if (free_ok) begin
        // The freed id goes straight to the allocator and never touches the stack.
        alloc_id_nxt = bus.free_id;
      end else if (!stack_empty) begin
        stack_pop    = 1'b1;
        alloc_id_nxt = stack_top;
      end else if (high_water_q < NArraysCnt) begin
        hw_inc       = 1'b1;
        alloc_id_nxt = W'(high_water_q);
      end else begin
        alloc_status = EXHAUSTED;
      end
    end
  end

  assign alloc_ok   = bus.alloc_req && (alloc_status == OK);
  assign stack_push = free_ok && !bus.alloc_req;
  assign alloc_idx  = alloc_id_nxt[IdxW-1:0];

  // Length tracking: index+1 at W+1 bits, saturating at all-ones.
  logic [W:0]   len_plus1;
  logic [W-1:0] len_cand;
  logic         len_upd;

  assign len_plus1 = {1'b0, bus.len_index} + (W + 1)'(1);
  assign len_cand  = len_plus1[W] ? '1 : len_plus1[W-1:0];
  assign len_upd   = bus.len_we && len_in_range && live[len_idx]
                   && !(free_ok && (bus.len_array == bus.free_id))
                   && ({1'b0, lens[len_idx]} < len_plus1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live         <= '0;
      for (int i = 0; i < NArrays; i++) begin
        lens[i] <= '0;
      end
      high_water_q <= '0;
      in_use_q     <= '0;
      alloc_id_q   <= '0;
      alloc_ack_q  <= 1'b0;
      alloc_err_q  <= 1'b0;
      free_ack_q   <= 1'b0;
      free_err_q   <= 1'b0;
    end else begin
      alloc_ack_q <= alloc_ok;
      alloc_err_q <= bus.alloc_req && !alloc_ok;
      free_ack_q  <= free_ok;
      free_err_q  <= bus.free_req && !free_ok;

      if (alloc_ok) begin
        alloc_id_q <= alloc_id_nxt;
      end
      if (hw_inc) begin
        high_water_q <= high_water_q + CountWidth'(1);
      end
      // A bypass both frees and allocates, so occupancy stays put.
      if (alloc_ok && !free_ok) begin
        in_use_q <= in_use_q + CountWidth'(1);
      end else if (free_ok && !alloc_ok) begin
        in_use_q <= in_use_q - CountWidth'(1);
      end

      // Later assignments win: a free or a fresh allocation clears the length.
      if (len_upd) begin
        lens[len_idx] <= len_cand;
      end
      if (free_ok) begin
        live[free_idx] <= 1'b0;
        lens[free_idx] <= '0;
      end
      if (alloc_ok) begin
        live[alloc_idx] <= 1'b1;
        lens[alloc_idx] <= '0;
      end
    end
  end

  assign bus.alloc_ack  = alloc_ack_q;
  assign bus.alloc_id   = alloc_id_q;
  assign bus.alloc_err  = alloc_err_q;
  assign bus.free_ack   = free_ack_q;
  assign bus.free_err   = free_err_q;
  assign bus.in_use     = in_use_q;
  assign bus.high_water = high_water_q;
  assign bus.rd_len     = rd_in_range ? lens[rd_idx] : '0;

endmodule

// File: tb/tb_array_allocator.sv
// Bench for array_allocator with NArrays=4: directed vector table, reset-abort sequence, randomized run against a model.
// Latency: responses are sampled 1 time unit after the edge that follows each request.
// Backpressure: none.
module tb_array_allocator;
  import zero_alloc_pkg::*;

  localparam int W  = 12;
  localparam int N  = 4;
  localparam int CW = count_width(N);
  localparam int LMAX = (1 << W) - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  array_allocator_if #(.MemoryElementWidth(W), .CountWidth(CW)) bus ();

  array_allocator #(
    .MemoryElementWidth (W),
    .NArrays            (N),
    .CountWidth         (CW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int aa, input int id, input int ae,
                         input int fa, input int fe, input int iu, input int hw, input int rl);
    chk({tag, " alloc_ack"},  int'(bus.alloc_ack),  aa);
    chk({tag, " alloc_id"},   int'(bus.alloc_id),   id);
    chk({tag, " alloc_err"},  int'(bus.alloc_err),  ae);
    chk({tag, " free_ack"},   int'(bus.free_ack),   fa);
    chk({tag, " free_err"},   int'(bus.free_err),   fe);
    chk({tag, " in_use"},     int'(bus.in_use),     iu);
    chk({tag, " high_water"}, int'(bus.high_water), hw);
    chk({tag, " rd_len"},     int'(bus.rd_len),     rl);
  endtask

  task automatic drive(input bit a, input bit f, input int fid, input bit lw,
                       input int la, input int li, input int rd);
    bus.alloc_req = a;
    bus.free_req  = f;
    bus.free_id   = W'(fid);
    bus.len_we    = lw;
    bus.len_array = W'(la);
    bus.len_index = W'(li);
    bus.rd_array  = W'(rd);
  endtask

  typedef struct {
    bit a; bit f; int fid; bit lw; int la; int li; int rd;
    int aa; int id; int ae; int fa; int fe; int iu; int hw; int rl;
  } vec_t;

  function automatic vec_t mk(bit a, bit f, int fid, bit lw, int la, int li, int rd,
                              int aa, int id, int ae, int fa, int fe, int iu, int hw, int rl);
    vec_t v;
    v.a = a; v.f = f; v.fid = fid; v.lw = lw; v.la = la; v.li = li; v.rd = rd;
    v.aa = aa; v.id = id; v.ae = ae; v.fa = fa; v.fe = fe; v.iu = iu; v.hw = hw; v.rl = rl;
    return v;
  endfunction

  // Reference model state
  bit   mlive [N];
  int   mlen  [N];
  int   mstack[$];
  int   mhw;
  int   mid;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mlive[i] = 1'b0;
      mlen[i]  = 0;
    end
    mstack.delete();
    mhw = 0;
    mid = 0;
  endtask

  vec_t tbl[$];

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    //              a f fid lw la li   rd   aa id ae fa fe iu hw rl
    tbl.push_back(mk(1,0,0, 0,0,0,    0,   1,0,0,0,0,1,1,0));  // fresh ids 0,1,2
    tbl.push_back(mk(1,0,0, 0,0,0,    0,   1,1,0,0,0,2,2,0));
    tbl.push_back(mk(1,0,0, 0,0,0,    0,   1,2,0,0,0,3,3,0));
    tbl.push_back(mk(0,1,0, 0,0,0,    0,   0,2,0,1,0,2,3,0));  // free 0, free 1
    tbl.push_back(mk(0,1,1, 0,0,0,    0,   0,2,0,1,0,1,3,0));
    tbl.push_back(mk(1,0,0, 0,0,0,    0,   1,1,0,0,0,2,3,0));  // LIFO: 1 then 0
    tbl.push_back(mk(1,0,0, 0,0,0,    0,   1,0,0,0,0,3,3,0));
    tbl.push_back(mk(1,0,0, 0,0,0,    0,   1,3,0,0,0,4,4,0));  // last fresh id
    tbl.push_back(mk(1,0,0, 0,0,0,    0,   0,3,1,0,0,4,4,0));  // exhausted, id held
    tbl.push_back(mk(0,1,2, 0,0,0,    0,   0,3,0,1,0,3,4,0));
    tbl.push_back(mk(1,0,0, 0,0,0,    0,   1,2,0,0,0,4,4,0));
    tbl.push_back(mk(0,1,5, 0,0,0,    0,   0,2,0,0,1,4,4,0));  // out of range
    tbl.push_back(mk(0,1,0, 0,0,0,    0,   0,2,0,1,0,3,4,0));  // free 0 twice
    tbl.push_back(mk(0,1,0, 0,0,0,    0,   0,2,0,0,1,3,4,0));
    tbl.push_back(mk(1,1,1, 0,0,0,    0,   1,1,0,1,0,3,4,0));  // bypass
    tbl.push_back(mk(1,0,0, 0,0,0,    0,   1,0,0,0,0,4,4,0));  // stack still held 0
    tbl.push_back(mk(0,0,0, 1,0,3,    0,   0,0,0,0,0,4,4,4));  // lengths 3,1,7
    tbl.push_back(mk(0,0,0, 1,0,1,    0,   0,0,0,0,0,4,4,4));
    tbl.push_back(mk(0,0,0, 1,0,7,    0,   0,0,0,0,0,4,4,8));
    tbl.push_back(mk(0,1,0, 0,0,0,    0,   0,0,0,1,0,3,4,0));  // free clears length
    tbl.push_back(mk(1,0,0, 0,0,0,    0,   1,0,0,0,0,4,4,0));
    tbl.push_back(mk(0,1,0, 1,0,5,    0,   0,0,0,1,0,3,4,0));  // free beats len_we
    tbl.push_back(mk(0,0,0, 1,0,9,    0,   0,0,0,0,0,3,4,0));  // non-live ignored
    tbl.push_back(mk(0,0,0, 1,9,2,    9,   0,0,0,0,0,3,4,0));  // out-of-range read
    tbl.push_back(mk(0,0,0, 1,1,LMAX, 1,   0,0,0,0,0,3,4,LMAX)); // saturation
    tbl.push_back(mk(0,0,0, 1,1,10,   1,   0,0,0,0,0,3,4,LMAX));
    tbl.push_back(mk(0,1,1, 0,0,0,    1,   0,0,0,1,0,2,4,0));

    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].f, tbl[i].fid, tbl[i].lw, tbl[i].la, tbl[i].li, tbl[i].rd);
      @(posedge clock);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].aa, tbl[i].id, tbl[i].ae, tbl[i].fa,
              tbl[i].fe, tbl[i].iu, tbl[i].hw, tbl[i].rl);
    end

    // Reset during a pending allocation: live {2,3}, stack holds 1 and 0.
    drive(0, 0, 0, 1, 2, 6, 2);
    @(posedge clock);
    #1;
    chk("pre-reset rd_len", int'(bus.rd_len), 7);
    drive(1, 0, 0, 0, 0, 0, 2);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all("async reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    chk_all("reset hold", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk_all("post-reset idle", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    chk_all("post-reset alloc", 1, 0, 0, 0, 0, 1, 1, 0);

    // Randomized run against the reference model
    drive(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    for (int c = 0; c < 1500; c++) begin
      bit a, f, lw, fok, lwok;
      int fid, la, li, rd, aid, e_aa, e_ae, e_fa, e_fe, e_iu, e_rl, newl;
      alloc_status_e fst;
      a   = ($urandom_range(0, 1) == 1);
      f   = ($urandom_range(0, 9) < 4);
      fid = ($urandom_range(0, 9) == 0) ? 4092 : int'($urandom_range(0, 5));
      lw  = ($urandom_range(0, 1) == 1);
      la  = int'($urandom_range(0, 5));
      li  = ($urandom_range(0, 15) == 0) ? LMAX : int'($urandom_range(0, 20));
      rd  = int'($urandom_range(0, 5));

      if (fid >= N)        fst = RANGE;
      else if (!mlive[fid]) fst = DOUBLE_FREE;
      else                 fst = OK;
      fok  = f && (fst == OK);
      e_fa = fok ? 1 : 0;
      e_fe = (f && !fok) ? 1 : 0;
      lwok = lw && (la < N) && (la < N ? mlive[la % N] : 1'b0) && !(fok && la == fid);

      aid  = -1;
      e_aa = 0;
      e_ae = 0;
      if (a) begin
        if (fok)                    aid = fid;
        else if (mstack.size() > 0) aid = mstack.pop_back();
        else if (mhw < N)           begin aid = mhw; mhw++; end
        else                        e_ae = 1;
      end
      if (lwok) begin
        newl = (li + 1 > LMAX) ? LMAX : li + 1;
        if (mlen[la] < newl) mlen[la] = newl;
      end
      if (fok) begin
        mlive[fid] = 1'b0;
        mlen[fid]  = 0;
        if (!a) mstack.push_back(fid);
      end
      if (aid >= 0) begin
        mlive[aid] = 1'b1;
        mlen[aid]  = 0;
        mid        = aid;
        e_aa       = 1;
      end
      e_iu = 0;
      for (int k = 0; k < N; k++) e_iu += mlive[k] ? 1 : 0;
      e_rl = (rd < N) ? mlen[rd] : 0;

      drive(a, f, fid, lw, la, li, rd);
      @(posedge clock);
      #1;
      chk_all($sformatf("rand%0d", c), e_aa, mid, e_ae, e_fa, e_fe, e_iu, mhw, e_rl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/array_allocator.md
Name: array_allocator

Overview:
Clocked, parametrised allocator for array handles in the zero VM FPGA fabric. Replaces the inline "array"/"free" instruction logic with one shared block.
- Hands out array ids from a LIFO freed-id stack, or from a fresh-allocation counter.
- Tracks per-array length.
- Detects exhaustion, double free and out-of-range ids.
- Reports occupancy and high-water statistics.

Parameters:
MemoryElementWidth, 12, width of array ids, lengths and indices
NArrays, 8, maximum number of simultaneously live arrays (1 to 2**MemoryElementWidth)
CountWidth, $clog2(NArrays+1), width of the occupancy and high-water counters

Ports:
clock  input  1  single system clock, rising edge
reset_n  input  1  asynchronous active-low reset
alloc_req  input  1  request a new array id this cycle
free_req  input  1  release free_id this cycle
free_id  input  MemoryElementWidth  id being released
alloc_ack  output  1  one-cycle pulse: alloc_id valid
alloc_id  output  MemoryElementWidth  allocated id, held until the next ack
alloc_err  output  1  one-cycle pulse: allocation refused (exhausted)
free_ack  output  1  one-cycle pulse: free accepted
free_err  output  1  one-cycle pulse: free refused (double free or out of range)
len_we  input  1  report a write to array len_array at index len_index
len_array  input  MemoryElementWidth  array being written
len_index  input  MemoryElementWidth  element index written
rd_array  input  MemoryElementWidth  array whose length is read
rd_len  output  MemoryElementWidth  combinational length of rd_array (0 if out of range)
in_use  output  CountWidth  number of live arrays
high_water  output  CountWidth  arrays ever created (fresh-counter value)

Behaviour:
- Reset (reset_n low, asynchronous): all acks/errs=0, alloc_id=0, in_use=0, high_water=0, stack top=0, live bitmap cleared, all lengths=0. Reset mid-request aborts it; no ack or err follows.
- All requests are sampled on the rising edge; the response appears the following cycle (latency 1). Back-to-back requests every cycle are legal.
- Allocation:
  - If the stack is non-empty: pop the top entry.
  - Else if high_water<NArrays: issue high_water and increment it.
  - Else: alloc_err=1; no state change.
  - On success: mark the id live, set its length to 0, increment in_use.
- Free:
  - Rejected with free_err=1, no state change, if free_id>=NArrays or free_id is not live.
  - Otherwise: push it, clear live, set length 0, decrement in_use, free_ack=1.
- Simultaneous alloc_req and free_req:
  - The free is evaluated first.
  - If it is accepted, the freed id bypasses the stack straight to the allocator: alloc_id=free_id, both acks pulse, stack unchanged, in_use unchanged.
  - If the free is rejected, the allocation proceeds as if it were alone.
- Length update:
  - On len_we with len_array live and in range: if length<len_index+1, set length=len_index+1. Otherwise no effect.
  - len_we to a non-live array is ignored silently.
  - When len_we and a free target the same array in the same cycle, the free wins (length ends at 0).
- Arithmetic:
  - len_index+1 is computed at MemoryElementWidth+1 bits.
  - If len_index=2**MemoryElementWidth-1, the length saturates at all-ones.
- Stack depth is NArrays. A push can never overflow, because the live bitmap bounds pushes.
- alloc_id holds its value between acks.

Decomposition:
- Package zero_alloc_pkg holds:
  - the MemoryElementWidth default;
  - id_t and len_t typedefs;
  - the CountWidth helper function;
  - an alloc_status_e enum (OK, EXHAUSTED, DOUBLE_FREE, RANGE) used internally and by the benches.
- One sub-module, array_free_stack: parametrised LIFO of ids with push, pop, top, empty and count. Push and pop in the same cycle are supported. Reset is asynchronous active-low.

Test Plan:
- Fresh allocation: after reset, three alloc_req pulses -> alloc_id 0,1,2; high_water=3, in_use=3.
- Reuse: alloc, alloc, free 0, free 1, alloc -> ids 0,1 then 1 (LIFO); high_water stays 2.
- Exhaustion with NArrays=4: five allocs -> ids 0..3 then alloc_err; in_use=4. Then free 2, alloc -> id 2.
- Error cases: free 5 with NArrays=4 -> free_err; free 0 twice -> free_ack then free_err; in_use decremented only once.
- Same-cycle bypass: live {0}; alloc_req and free_req(0) together -> alloc_ack and free_ack, alloc_id=0, in_use=1, stack empty.
- Lengths and reset: len_we on array 0 with indices 3,1,7 -> rd_len=8. Free 0 -> rd_len=0. Assert reset_n mid-allocation -> no ack, and all outputs are 0 immediately.
